// File: rtl/crypto_stream_adapter.sv
// crypto_stream_adapter
//   Bridges 32-bit word streams to the 128-bit block encryption host.
//   Four plaintext words (MSB first) are packed into one block and sent to the
//   host with a start pulse. The adapter then waits for done, captures the
//   ciphertext and replays it as four words on a valid/ready stream.
//   A watchdog aborts a host operation that never completes and raises a
//   sticky error flag.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   key_data/key_load cipher key and its load strobe (honoured only in FILL)
//   s_data/s_valid/s_ready     plaintext word input stream
//   plaintext, cipher_key, encrypt_start   request to the encryption host
//   ciphertext, encrypt_done               response from the encryption host
//   m_data/m_valid/m_ready/m_last          ciphertext word output stream
//   busy              high whenever the adapter is not collecting input
//   timeout_err       sticky watchdog flag, cleared by err_clr
//
// state   | meaning
// --------+---------------------------------------------------------------
// FILL    | collect four plaintext words, accept key loads
// START   | one-cycle encrypt_start pulse to the host
// WAIT    | wait for encrypt_done, watchdog counting
// CAPTURE | wait out the host's ciphertext register delay, then latch it
// DRAIN   | present four ciphertext words on the output stream

module crypto_stream_adapter #(
  parameter int CAPTURE_DELAY  = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_data,
  input  logic         key_load,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [127:0] plaintext,
  output logic [127:0] cipher_key,
  output logic         encrypt_start,
  input  logic [127:0] ciphertext,
  input  logic         encrypt_done,
  output logic [31:0]  m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last,
  output logic         busy,
  output logic         timeout_err,
  input  logic         err_clr
);

  typedef enum logic [2:0] {
    S_FILL,
    S_START,
    S_WAIT,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  localparam logic [7:0] TIMEOUT_TC = 8'(TIMEOUT_CYCLES);
  // CAPTURE lasts CAPTURE_DELAY cycles; latch on its last one.
  localparam logic [7:0] CAPTURE_TC = (CAPTURE_DELAY > 0) ? 8'(CAPTURE_DELAY - 1) : 8'd0;

  state_t       state_q, state_d;
  logic [1:0]   word_cnt_q, word_cnt_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [127:0] plaintext_q, plaintext_d;
  logic [127:0] cipher_key_q, cipher_key_d;
  logic [127:0] obuf_q, obuf_d;
  logic [31:0]  m_data_q, m_data_d;
  logic         s_ready_q, s_ready_d;
  logic         encrypt_start_q, encrypt_start_d;
  logic         m_valid_q, m_valid_d;
  logic         m_last_q, m_last_d;
  logic         busy_q, busy_d;
  logic         timeout_err_q, timeout_err_d;

  function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] idx);
    case (idx)
      2'd0:    return blk[127:96];
      2'd1:    return blk[95:64];
      2'd2:    return blk[63:32];
      default: return blk[31:0];
    endcase
  endfunction

  always_comb begin
    state_d         = state_q;
    word_cnt_d      = word_cnt_q;
    cnt_d           = cnt_q;
    plaintext_d     = plaintext_q;
    cipher_key_d    = cipher_key_q;
    obuf_d          = obuf_q;
    m_data_d        = m_data_q;
    s_ready_d       = s_ready_q;
    encrypt_start_d = 1'b0;
    m_valid_d       = m_valid_q;
    m_last_d        = m_last_q;
    busy_d          = busy_q;
    timeout_err_d   = timeout_err_q;

    // A timeout raised below overrides this clear.
    if (err_clr) timeout_err_d = 1'b0;

    case (state_q)
      S_FILL: begin
        if (key_load) cipher_key_d = key_data;
        if (s_valid && s_ready_q) begin
          case (word_cnt_q)
            2'd0:    plaintext_d[127:96] = s_data;
            2'd1:    plaintext_d[95:64]  = s_data;
            2'd2:    plaintext_d[63:32]  = s_data;
            default: plaintext_d[31:0]   = s_data;
          endcase
          word_cnt_d = word_cnt_q + 2'd1;
          if (word_cnt_q == 2'd3) begin
            state_d         = S_START;
            s_ready_d       = 1'b0;
            encrypt_start_d = 1'b1;
            busy_d          = 1'b1;
          end
        end
      end

      S_START: begin
        state_d = S_WAIT;
        cnt_d   = 8'd0;
      end

      S_WAIT: begin
        if (encrypt_done) begin
          cnt_d = 8'd0;
          if (CAPTURE_DELAY == 0) begin
            obuf_d    = ciphertext;
            m_data_d  = word_sel(ciphertext, 2'd0);
            m_valid_d = 1'b1;
            m_last_d  = 1'b0;
            state_d   = S_DRAIN;
          end else begin
            state_d = S_CAPTURE;
          end
        end else if (cnt_q + 8'd1 == TIMEOUT_TC) begin
          // Abort: the block is dropped and nothing is emitted.
          timeout_err_d = 1'b1;
          cnt_d         = 8'd0;
          word_cnt_d    = 2'd0;
          s_ready_d     = 1'b1;
          busy_d        = 1'b0;
          state_d       = S_FILL;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_CAPTURE: begin
        if (cnt_q == CAPTURE_TC) begin
          obuf_d    = ciphertext;
          m_data_d  = word_sel(ciphertext, 2'd0);
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          cnt_d     = 8'd0;
          state_d   = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_DRAIN: begin
        if (m_valid_q && m_ready) begin
          if (word_cnt_q == 2'd3) begin
            m_valid_d  = 1'b0;
            m_last_d   = 1'b0;
            s_ready_d  = 1'b1;
            busy_d     = 1'b0;
            word_cnt_d = 2'd0;
            state_d    = S_FILL;
          end else begin
            word_cnt_d = word_cnt_q + 2'd1;
            m_data_d   = word_sel(obuf_q, word_cnt_q + 2'd1);
            m_last_d   = (word_cnt_q == 2'd2);
          end
        end
      end

      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_FILL;
      word_cnt_q      <= 2'd0;
      cnt_q           <= 8'd0;
      plaintext_q     <= '0;
      cipher_key_q    <= '0;
      obuf_q          <= '0;
      m_data_q        <= '0;
      s_ready_q       <= 1'b1;
      encrypt_start_q <= 1'b0;
      m_valid_q       <= 1'b0;
      m_last_q        <= 1'b0;
      busy_q          <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      word_cnt_q      <= word_cnt_d;
      cnt_q           <= cnt_d;
      plaintext_q     <= plaintext_d;
      cipher_key_q    <= cipher_key_d;
      obuf_q          <= obuf_d;
      m_data_q        <= m_data_d;
      s_ready_q       <= s_ready_d;
      encrypt_start_q <= encrypt_start_d;
      m_valid_q       <= m_valid_d;
      m_last_q        <= m_last_d;
      busy_q          <= busy_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  assign s_ready       = s_ready_q;
  assign plaintext     = plaintext_q;
  assign cipher_key    = cipher_key_q;
  assign encrypt_start = encrypt_start_q;
  assign m_data        = m_data_q;
  assign m_valid       = m_valid_q;
  assign m_last        = m_last_q;
  assign busy          = busy_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_crypto_stream_adapter.sv
// Testbench for crypto_stream_adapter: a behavioural encryption host plus a
// word-level reference model (expected block = words in arrival order,
// expected output = host function of that block and the last key loaded in FILL).

module tb_crypto_stream_adapter;

  localparam int CD = 1;
  localparam int TO = 64;

  logic         clk;
  logic         rst;
  logic [127:0] key_data;
  logic         key_load;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] plaintext;
  logic [127:0] cipher_key;
  logic         encrypt_start;
  logic [127:0] ciphertext;
  logic         encrypt_done;
  logic [31:0]  m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;
  logic         busy;
  logic         timeout_err;
  logic         err_clr;

  crypto_stream_adapter #(.CAPTURE_DELAY(CD), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .key_data(key_data), .key_load(key_load),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .plaintext(plaintext), .cipher_key(cipher_key), .encrypt_start(encrypt_start),
    .ciphertext(ciphertext), .encrypt_done(encrypt_done),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Host behaviour: ciphertext is garbage during the done cycle and becomes
  // the real result one cycle later.
  function automatic logic [127:0] host_result(input logic [127:0] pt, input logic [127:0] key,
                                               input logic fixed);
    if (fixed) return {4{32'hA5A5A5A5}};
    return pt ^ {key[63:0], key[127:64]} ^ 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  endfunction

  logic         host_en;
  logic         host_fixed;
  int           host_lat;
  logic         host_busy;
  logic         ct_pending;
  int           host_rem;
  logic [127:0] host_pt, host_key;

  initial begin
    encrypt_done = 1'b0;
    ciphertext   = '0;
    host_busy    = 1'b0;
    ct_pending   = 1'b0;
    host_rem     = 0;
    host_pt      = '0;
    host_key     = '0;
    forever begin
      tick();
      encrypt_done = 1'b0;
      if (ct_pending) begin
        ciphertext = host_result(host_pt, host_key, host_fixed);
        ct_pending = 1'b0;
      end
      if (host_busy) begin
        host_rem--;
        if (host_rem == 0) begin
          host_busy = 1'b0;
          if (host_en) begin
            encrypt_done = 1'b1;
            ciphertext   = rand128();
            ct_pending   = 1'b1;
          end
        end
      end else if (encrypt_start === 1'b1) begin
        host_busy = 1'b1;
        host_rem  = host_lat;
        host_pt   = plaintext;
        host_key  = cipher_key;
      end
    end
  end

  logic [127:0] exp_key;

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_plaintext", plaintext, 128'(0));
    check_eq("rst_cipher_key", cipher_key, 128'(0));
    check_eq("rst_m_data", 128'(m_data), 128'(0));
    check_eq("rst_s_ready", 128'(s_ready), 128'(1));
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_m_valid", 128'(m_valid), 128'(0));
    check_eq("rst_m_last", 128'(m_last), 128'(0));
    check_eq("rst_start", 128'(encrypt_start), 128'(0));
    check_eq("rst_timeout_err", 128'(timeout_err), 128'(0));
    exp_key  = '0;
    s_valid  = 1'b0;
    key_load = 1'b0;
    m_ready  = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_load = 1'b1;
    key_data = k;
    tick();
    key_load = 1'b0;
    exp_key  = k;
  endtask

  // Returns in the START cycle.
  task automatic send_block(input logic [127:0] blk, input bit gaps, input bit key_last,
                            input logic [127:0] k);
    for (int i = 0; i < 4; i++) begin
      if (gaps && i > 0) begin
        s_valid  = 1'b0;
        s_data   = $urandom();
        key_data = rand128();
        tick();
      end
      check_eq("s_ready_fill", 128'(s_ready), 128'(1));
      s_valid = 1'b1;
      s_data  = blk[127-32*i -: 32];
      if (i == 3 && key_last) begin
        key_load = 1'b1;
        key_data = k;
        exp_key  = k;
      end
      tick();
      s_valid  = 1'b0;
      key_load = 1'b0;
      key_data = rand128();
    end
    check_eq("start_pulse", 128'(encrypt_start), 128'(1));
    check_eq("start_plaintext", plaintext, blk);
    check_eq("start_key", cipher_key, exp_key);
    check_eq("s_ready_start", 128'(s_ready), 128'(0));
    check_eq("busy_start", 128'(busy), 128'(1));
  endtask

  task automatic drain_block(input logic [127:0] exp_ct, input int stall_word, input bit key_in_wait);
    int waited;
    tick();
    waited = 1;
    check_eq("start_single", 128'(encrypt_start), 128'(0));
    if (key_in_wait) begin
      key_load = 1'b1;
      key_data = rand128();
    end
    while (m_valid !== 1'b1 && waited < 400) begin
      tick();
      key_load = 1'b0;
      waited++;
    end
    key_load = 1'b0;
    check_eq("latency", 128'(waited), 128'(host_lat + CD + 1));
    check_eq("key_hold", cipher_key, exp_key);
    for (int i = 0; i < 4; i++) begin
      int stall;
      logic [31:0] w;
      w     = exp_ct[127-32*i -: 32];
      stall = (i == stall_word) ? 5 : int'($urandom_range(0, 2));
      for (int s = 0; s <= stall; s++) begin
        m_ready = (s == stall);
        check_eq("m_valid", 128'(m_valid), 128'(1));
        check_eq($sformatf("m_data_w%0d", i), 128'(m_data), 128'(w));
        check_eq("m_last", 128'(m_last), 128'(i == 3));
        check_eq("s_ready_drain", 128'(s_ready), 128'(0));
        tick();
      end
    end
    m_ready = 1'b0;
    check_eq("post_m_valid", 128'(m_valid), 128'(0));
    check_eq("post_s_ready", 128'(s_ready), 128'(1));
    check_eq("post_busy", 128'(busy), 128'(0));
    check_eq("post_timeout_err", 128'(timeout_err), 128'(0));
  endtask

  task automatic run_block(input logic [127:0] blk, input bit gaps, input bit key_last,
                           input logic [127:0] k, input int stall_word, input bit key_in_wait);
    logic [127:0] exp_ct;
    send_block(blk, gaps, key_last, k);
    exp_ct = host_result(blk, exp_key, host_fixed);
    drain_block(exp_ct, stall_word, key_in_wait);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not end, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst        = 1'b0;
    key_data   = '0;
    key_load   = 1'b0;
    s_data     = '0;
    s_valid    = 1'b0;
    m_ready    = 1'b0;
    err_clr    = 1'b0;
    host_en    = 1'b1;
    host_fixed = 1'b0;
    host_lat   = 2;
    exp_key    = '0;

    async_reset();
    tick();

    // Basic block with a fixed host result.
    load_key(128'h000102030405060708090A0B0C0D0E0F);
    host_fixed = 1'b1;
    host_lat   = 3;
    run_block(128'h11111111222222223333333344444444, 1'b0, 1'b0, '0, -1, 1'b0);
    host_fixed = 1'b0;

    // Back-pressure: five stalled cycles on the second output word.
    host_lat = 2;
    run_block(rand128(), 1'b0, 1'b0, '0, 1, 1'b0);

    // Gapped input.
    host_lat = 4;
    run_block(rand128(), 1'b1, 1'b0, '0, -1, 1'b0);

    // Key load with the 4th word, and a key load during WAIT that must be ignored.
    host_lat = 5;
    run_block(rand128(), 1'b0, 1'b1, rand128(), -1, 1'b1);

    // Timeout, with err_clr held high so the set has to win.
    host_en = 1'b0;
    send_block(rand128(), 1'b0, 1'b0, '0);
    err_clr = 1'b1;
    cnt = 0;
    while (timeout_err !== 1'b1 && cnt < 300) begin
      check_eq("timeout_no_m_valid", 128'(m_valid), 128'(0));
      tick();
      cnt++;
    end
    err_clr = 1'b0;
    check_eq("timeout_cycles", 128'(cnt), 128'(TO + 1));
    check_eq("timeout_set", 128'(timeout_err), 128'(1));
    check_eq("timeout_s_ready", 128'(s_ready), 128'(1));
    check_eq("timeout_busy", 128'(busy), 128'(0));
    repeat (3) tick();
    check_eq("timeout_sticky", 128'(timeout_err), 128'(1));
    check_eq("timeout_m_valid", 128'(m_valid), 128'(0));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("timeout_cleared", 128'(timeout_err), 128'(0));
    host_en = 1'b1;

    // Block after a timeout must start from a fresh word count.
    host_lat = 1;
    run_block(rand128(), 1'b0, 1'b0, '0, -1, 1'b0);

    // Reset after two words; fresh words must fully replace them.
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data  = $urandom();
      tick();
    end
    s_valid = 1'b0;
    async_reset();
    host_lat = 3;
    run_block(rand128(), 1'b0, 1'b0, '0, -1, 1'b0);

    // Reset during WAIT: the host's late done lands in FILL and is ignored.
    host_lat = 6;
    load_key(rand128());
    send_block(rand128(), 1'b0, 1'b0, '0);
    tick();
    tick();
    async_reset();
    for (int i = 0; i < 8; i++) begin
      check_eq("stale_m_valid", 128'(m_valid), 128'(0));
      check_eq("stale_busy", 128'(busy), 128'(0));
      check_eq("stale_s_ready", 128'(s_ready), 128'(1));
      tick();
    end
    cnt = 0;
    while ((host_busy || ct_pending) && cnt < 20) begin
      tick();
      cnt++;
    end
    host_lat = 2;
    run_block(rand128(), 1'b0, 1'b0, '0, -1, 1'b0);

    // Randomized blocks.
    for (int n = 0; n < 20; n++) begin
      bit gaps, klast, kwait;
      int sw;
      if ($urandom_range(0, 2) == 0) load_key(rand128());
      host_lat = int'($urandom_range(1, 6));
      gaps  = 1'($urandom_range(0, 1));
      klast = ($urandom_range(0, 3) == 0);
      kwait = ($urandom_range(0, 3) == 0);
      sw    = int'($urandom_range(0, 5)) - 1;
      run_block(rand128(), gaps, klast, rand128(), sw, kwait);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
